encaps_sequencer: RTL and testbench
===================================

# encaps_sequencer

Top-level sequencer for the encapsulation datapath. It runs the h-unpack unit and the ternary sampler in parallel, then the S3 packer, then the SHA3-256 absorb/permute, and signals completion. It replaces ad-hoc gated-clock control with enables and single-cycle strobes on one clock domain. It sits between the host start/done handshake and the `unpack_rq0`, `ternary`, `pack_s3` and `sha3_256` units.

## Interface
- `PACK_BYTES`, default 136: packed-message bytes; pack phase lasts `4*PACK_BYTES` cycles.
- `ROUNDS`, default 24: Keccak rounds per permutation.
- `TIMEOUT`, default 1023: maximum FETCH cycles before error. 10-bit counter; legal range 1..1023.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `abort`  in  1  synchronous cancel; highest priority after reset.
- `up_done`  in  1  unpack unit finished (level or pulse).
- `ter_done`  in  1  ternary sampler finished (level or pulse).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse in FINISH.
- `err`  out  1  sticky FETCH timeout flag; cleared by the next accepted `start` or by reset.
- `state`  out  3  IDLE=0, CLEAR=1, FETCH=2, PACK=3, HLOAD=4, HRUN=5, FINISH=6, ERROR=7.
- `sub_rst`  out  1  one-cycle synchronous clear to all datapath units.
- `up_en`  out  1  unpack enable.
- `ter_en`  out  1  ternary enable.
- `pack_en`  out  1  packer enable.
- `pack_count`  out  2  packer sub-cycle index.
- `hash_load`  out  1  absorb-block strobe.
- `hash_round_en`  out  1  Keccak round enable.
- `round_idx`  out  5  current round number.
- `hash_fin`  out  1  digest-capture strobe, coincident with `done`.

## Operation
- **Reset:** `state`=IDLE. All outputs 0. Internal counters and flags 0.
- **IDLE:** `start`=1 moves to CLEAR and clears `err`. `start` is ignored in every other state.
- **CLEAR:** one cycle with `sub_rst`=1, then FETCH. Clears `up_seen`, `ter_seen` and the FETCH counter.
- **FETCH:**
  - `up_en` = !`up_seen`; `ter_en` = !`ter_seen`.
  - A sampled `up_done`=1 sets `up_seen`; `up_en` drops the next cycle. Same rule for `ter_done`/`ter_seen`.
  - Both done inputs may arrive in the same cycle, or either may arrive first.
  - The state exits to PACK on the edge where (`up_seen`|`up_done`) & (`ter_seen`|`ter_done`) is true.
  - The FETCH counter increments every cycle. If it reaches `TIMEOUT` and the join condition is false, go to ERROR. If the join and the timeout occur on the same edge, the join wins.
- **PACK:** `pack_en`=1 for exactly `4*PACK_BYTES` cycles. `pack_count` runs 0,1,2,3 and wraps; it is 0 on the first PACK cycle. Then HLOAD.
- **HLOAD:** one cycle, `hash_load`=1. Then HRUN.
- **HRUN:** `hash_round_en`=1 for `ROUNDS` cycles; `round_idx` runs 0..ROUNDS-1. Then FINISH.
- **FINISH:** one cycle, `done`=`hash_fin`=1. Then IDLE.
- **ERROR:** `err`=1 and `busy`=1. All enables and strobes are 0. The state leaves only on `abort` (to IDLE, `err` stays 1) or on reset.
- **abort:**
  - In any non-IDLE state, the next state is IDLE.
  - All enables, strobes and counters clear on that edge.
  - `done` is not pulsed.
  - `err` is preserved.
- **Done inputs outside FETCH** are ignored.
- **Output registration:** all outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.

## Timing
- Let `start` be sampled at edge 0, and let the join occur at the end of FETCH cycle F (F≥1; cycle 2 is the first FETCH cycle).
- Phase positions:
  - CLEAR: cycle 1.
  - PACK: cycles 2+F .. 1+F+4·PACK_BYTES.
  - HLOAD: cycle 2+F+4·PACK_BYTES.
  - HRUN: the next `ROUNDS` cycles.
  - `done`: cycle 3+F+4·PACK_BYTES+ROUNDS.
- With defaults and F=1, `done` is high in cycle 572.
- `busy` rises in cycle 1 and falls in the cycle after `done`.
- A new `start` is accepted in the cycle immediately after FINISH, giving back-to-back operation.
- Asynchronous reset mid-operation forces IDLE and zeroes all outputs immediately, without waiting for a clock edge.

## Test plan
- **Nominal run:** `start` at cycle 0, `up_done` and `ter_done` pulsed together in cycle 2.
  - `sub_rst` high in cycle 1.
  - `pack_en` high for cycles 3..546, `pack_count` pattern 0,1,2,3 repeating.
  - `hash_load` high in cycle 547.
  - `round_idx` runs 0..23 over cycles 548..571.
  - `done`=`hash_fin`=1 in cycle 572 only.
- **Skewed join:** `ter_done` in cycle 5, `up_done` in cycle 40.
  - `ter_en` is low from cycle 6.
  - `up_en` is low from cycle 41.
  - PACK starts in cycle 41.
  - `done` occurs in cycle 610.
- **Timeout:** `TIMEOUT`=16, `up_done` never asserted.
  - ERROR after 16 FETCH cycles; `err`=1, `busy`=1.
  - `abort` returns to IDLE with `err` still 1.
  - The next `start` clears `err`.
- **Abort mid-HRUN** (at `round_idx`=10): IDLE next cycle, all enables 0, no `done`. A subsequent full run completes normally.
- **Busy start, back-to-back, reset:**
  - `start` held high throughout the run causes no restart mid-run.
  - A second run begins in the cycle after FINISH.
  - `rst_n` pulsed low in PACK clears all outputs asynchronously.

Source files
------------

// File: rtl/encaps_sequencer.sv
// encaps_sequencer: start/done control for the encapsulation datapath.
// Runs unpack+ternary in parallel, then packing, then SHA3 absorb/rounds.
module encaps_sequencer #(
    parameter int PACK_BYTES = 136,
    parameter int ROUNDS     = 24,
    parameter int TIMEOUT    = 1023
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       up_done,
    input  logic       ter_done,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] state,
    output logic       sub_rst,
    output logic       up_en,
    output logic       ter_en,
    output logic       pack_en,
    output logic [1:0] pack_count,
    output logic       hash_load,
    output logic       hash_round_en,
    output logic [4:0] round_idx,
    output logic       hash_fin
);

    localparam int PACK_CYC = 4 * PACK_BYTES;
    localparam int PW = (PACK_CYC > 2) ? $clog2(PACK_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        FETCH  = 3'd2,
        PACK   = 3'd3,
        HLOAD  = 3'd4,
        HRUN   = 3'd5,
        FINISH = 3'd6,
        ERROR  = 3'd7
    } state_t;

    state_t        st;
    logic          up_seen;
    logic          ter_seen;
    logic [9:0]    fetch_cnt;
    logic [PW-1:0] pack_cyc;
    logic          up_hit;
    logic          ter_hit;

    // A done seen earlier or arriving this cycle both count toward the join
    assign up_hit  = up_seen | up_done;
    assign ter_hit = ter_seen | ter_done;
    assign state   = st;

    // Sequencer: outputs are loaded for the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st            <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            sub_rst       <= 1'b0;
            up_en         <= 1'b0;
            ter_en        <= 1'b0;
            pack_en       <= 1'b0;
            pack_count    <= 2'd0;
            hash_load     <= 1'b0;
            hash_round_en <= 1'b0;
            round_idx     <= 5'd0;
            hash_fin      <= 1'b0;
            up_seen       <= 1'b0;
            ter_seen      <= 1'b0;
            fetch_cnt     <= 10'd0;
            pack_cyc      <= '0;
        end else begin
            sub_rst       <= 1'b0;
            up_en         <= 1'b0;
            ter_en        <= 1'b0;
            pack_en       <= 1'b0;
            hash_load     <= 1'b0;
            hash_round_en <= 1'b0;
            done          <= 1'b0;
            hash_fin      <= 1'b0;
            if (abort && st != IDLE) begin
                st         <= IDLE;
                busy       <= 1'b0;
                pack_count <= 2'd0;
                round_idx  <= 5'd0;
                up_seen    <= 1'b0;
                ter_seen   <= 1'b0;
                fetch_cnt  <= 10'd0;
                pack_cyc   <= '0;
            end else begin
                case (st)
                    IDLE: begin
                        if (start) begin
                            st      <= CLEAR;
                            err     <= 1'b0;
                            busy    <= 1'b1;
                            sub_rst <= 1'b1;
                        end
                    end
                    CLEAR: begin
                        st        <= FETCH;
                        up_seen   <= 1'b0;
                        ter_seen  <= 1'b0;
                        fetch_cnt <= 10'd0;
                        up_en     <= 1'b1;
                        ter_en    <= 1'b1;
                    end
                    FETCH: begin
                        fetch_cnt <= fetch_cnt + 10'd1;
                        up_seen   <= up_hit;
                        ter_seen  <= ter_hit;
                        if (up_hit && ter_hit) begin
                            st         <= PACK;
                            pack_en    <= 1'b1;
                            pack_count <= 2'd0;
                            pack_cyc   <= '0;
                        end else if (fetch_cnt == 10'(TIMEOUT - 1)) begin
                            st  <= ERROR;
                            err <= 1'b1;
                        end else begin
                            up_en  <= !up_hit;
                            ter_en <= !ter_hit;
                        end
                    end
                    PACK: begin
                        if (pack_cyc == PW'(PACK_CYC - 1)) begin
                            st         <= HLOAD;
                            hash_load  <= 1'b1;
                            pack_count <= 2'd0;
                        end else begin
                            pack_cyc   <= pack_cyc + 1'b1;
                            pack_count <= pack_count + 2'd1;
                            pack_en    <= 1'b1;
                        end
                    end
                    HLOAD: begin
                        st            <= HRUN;
                        hash_round_en <= 1'b1;
                        round_idx     <= 5'd0;
                    end
                    HRUN: begin
                        if (round_idx == 5'(ROUNDS - 1)) begin
                            st        <= FINISH;
                            round_idx <= 5'd0;
                            done      <= 1'b1;
                            hash_fin  <= 1'b1;
                        end else begin
                            round_idx     <= round_idx + 5'd1;
                            hash_round_en <= 1'b1;
                        end
                    end
                    FINISH: begin
                        st   <= IDLE;
                        busy <= 1'b0;
                    end
                    ERROR: begin
                        st <= ERROR;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_encaps_sequencer.sv
// tb_encaps_sequencer: randomized runs against a timing-formula model.
// Expected outputs per cycle are derived from run start, join and abort.
module tb_encaps_sequencer;

    localparam int PB    = 136;
    localparam int RN    = 24;
    localparam int TO    = 64;
    localparam int NEVER = 100000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       up_done = 1'b0;
    logic       ter_done = 1'b0;
    logic       busy, done, err;
    logic [2:0] state;
    logic       sub_rst, up_en, ter_en, pack_en;
    logic [1:0] pack_count;
    logic       hash_load, hash_round_en;
    logic [4:0] round_idx;
    logic       hash_fin;

    encaps_sequencer #(
        .PACK_BYTES(PB),
        .ROUNDS(RN),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .up_done(up_done),
        .ter_done(ter_done),
        .busy(busy),
        .done(done),
        .err(err),
        .state(state),
        .sub_rst(sub_rst),
        .up_en(up_en),
        .ter_en(ter_en),
        .pack_en(pack_en),
        .pack_count(pack_count),
        .hash_load(hash_load),
        .hash_round_en(hash_round_en),
        .round_idx(round_idx),
        .hash_fin(hash_fin)
    );

    always #5 clk = ~clk;

    logic [19:0] ov;
    assign ov = {busy, done, err, state, sub_rst, up_en, ter_en, pack_en,
                 pack_count, hash_load, hash_round_en, round_idx, hash_fin};

    int   n_chk = 0;
    int   n_pass = 0;
    int   r_du, r_dt, r_f, r_last;
    bit   r_to_hit;
    logic err_prev = 1'b0;

    task automatic check(input string tag, input logic [19:0] got,
                         input logic [19:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected output vector in run-relative cycle c (c=0: start cycle)
    function automatic logic [19:0] expv(input int c);
        logic       b, d, e, sr, ue, te, pe, hl, hr, hf;
        logic [2:0] s;
        logic [1:0] pc;
        logic [4:0] ri;
        int p0, h0, dn;
        b = 0; d = 0; sr = 0; ue = 0; te = 0; pe = 0;
        hl = 0; hr = 0; hf = 0; s = 0; pc = 0; ri = 0;
        p0 = 2 + r_f;
        h0 = p0 + 4 * PB;
        dn = h0 + 1 + RN;
        e = (c == 0) ? err_prev : (r_to_hit && c >= 2 + TO);
        if (c >= 1 && c <= r_last) begin
            b = 1;
            if (c == 1) begin
                s = 3'd1; sr = 1;
            end else if (r_to_hit && c >= 2 + TO) begin
                s = 3'd7;
            end else if (r_to_hit || c < p0) begin
                s = 3'd2; ue = (c <= r_du); te = (c <= r_dt);
            end else if (c < h0) begin
                s = 3'd3; pe = 1; pc = 2'((c - p0) % 4);
            end else if (c == h0) begin
                s = 3'd4; hl = 1;
            end else if (c < dn) begin
                s = 3'd5; hr = 1; ri = 5'(c - h0 - 1);
            end else begin
                s = 3'd6; d = 1; hf = 1;
            end
        end
        return {b, d, e, s, sr, ue, te, pe, pc, hl, hr, ri, hf};
    endfunction

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            check("idle", ov, expv(0));
            start    = 0;
            abort    = 1'($urandom_range(0, 1));
            up_done  = 1'($urandom_range(0, 1));
            ter_done = 1'($urandom_range(0, 1));
            step();
        end
        abort = 0; up_done = 0; ter_done = 0;
    endtask

    // du/dt: cycle of first done; ab: abort cycle (0 none); rst_at: -1 none
    task automatic run_case(input int du, input int dt, input int ab,
                            input bit hold, input bit lvl,
                            input int rst_at);
        int  mx, dn, fe;
        bit  nu, nt, did_rst;
        mx       = (du > dt) ? du : dt;
        r_du     = du;
        r_dt     = dt;
        r_f      = mx - 1;
        r_to_hit = (r_f > TO);
        dn       = 3 + r_f + 4 * PB + RN;
        if (r_to_hit) r_last = ab;
        else r_last = (ab > 0 && ab < dn) ? ab : dn;
        if (rst_at >= 0 && rst_at < r_last) r_last = rst_at;
        fe      = r_to_hit ? 1 + TO : 1 + r_f;
        did_rst = 0;
        for (int c = 0; c <= r_last; c++) begin
            check($sformatf("cyc%0d", c), ov, expv(c));
            if (c == rst_at) begin
                #2 rst_n = 0;
                #1 check("async_rst", ov, 20'd0);
                #2 rst_n = 1;
                did_rst = 1;
            end
            nu = (c == 1 || c > fe) && ($urandom_range(0, 2) == 0);
            nt = (c == 1 || c > fe) && ($urandom_range(0, 2) == 0);
            start    = (c == 0) || (hold && !did_rst);
            abort    = (c == ab) && (c > 0);
            up_done  = (lvl ? (c >= du) : (c == du)) || nu;
            ter_done = (lvl ? (c >= dt) : (c == dt)) || nt;
            step();
        end
        start = 0; abort = 0; up_done = 0; ter_done = 0;
        err_prev = did_rst ? 1'b0 : 1'(r_to_hit);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int du, dt, ab;
        #2 check("reset", ov, 20'd0);
        #10 rst_n = 1;
        step();
        gap(2);
        run_case(2, 2, 0, 0, 0, -1);
        gap(1);
        run_case(40, 5, 0, 0, 0, -1);
        gap(1);
        run_case(TO + 1, 3, 0, 0, 1, -1);
        run_case(NEVER, 4, 2 + TO + 3, 0, 0, -1);
        gap(3);
        run_case(3, 2, 0, 0, 0, -1);
        run_case(TO + 2, TO + 2, 2 + TO, 0, 0, -1);
        run_case(2, 3, 3 + 2 + 4 * PB + 10, 0, 0, -1);
        run_case(2, 2, 0, 0, 0, -1);
        gap(2);
        run_case(3, 3, 0, 1, 0, -1);
        run_case(4, 2, 0, 1, 1, -1);
        run_case(2, 6, 0, 0, 0, -1);
        gap(1);
        run_case(5, 2, 0, 0, 0, 100);
        gap(2);
        for (int k = 0; k < 8; k++) begin
            du = $urandom_range(2, TO + 3);
            dt = $urandom_range(2, TO + 3);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 600) : 0;
            if (((du > dt) ? du : dt) - 1 > TO)
                ab = 2 + TO + $urandom_range(0, 5);
            run_case(du, dt, ab, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), -1);
            gap($urandom_range(0, 2));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
